pipearch_fifo_source: RTL and testbench
=======================================

# pipearch_fifo_source

Synchronous BRAM-backed FIFO that implements the `fifo_source` side of `fifobram_interface`, serving the producer holding `fifo_write` and the consumer holding `fifo_read`. It decouples the memory read path from compute pipelines inside a PipeArch engine. It provides registered `empty`, `almostfull` and `count` status and a one-cycle `rdata`/`rvalid` read response.

## Interface
Parameters:
- `WIDTH`, 32, data word width; must match the bound interface.
- `LOG2_DEPTH`, 5, address width; capacity `CAP = 2**LOG2_DEPTH - 1` entries, so `count` fits in `LOG2_DEPTH` bits.
- `ALMOSTFULL_SLACK`, 4, free-entry margin; must satisfy 1 ≤ slack ≤ CAP.

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `fifo.we`  in  1  write request.
- `fifo.wdata`  in  WIDTH  write data.
- `fifo.re`  in  1  read request.
- `fifo.rdata`  out  WIDTH  read data; reset value 0.
- `fifo.rvalid`  out  1  read-data valid pulse; reset value 0.
- `fifo.almostfull`  out  1  reset value 0.
- `fifo.empty`  out  1  reset value 1.
- `fifo.count`  out  LOG2_DEPTH  current occupancy; reset value 0.
- `error`  out  2  sticky {overflow, underflow}; reset value 0. Tied to 0 when `PIPEARCH_FIFO_CHECK_EN` is undefined.

`fifo` is a `fifobram_interface.fifo_source` modport port.

## Operation
- State consists of `wptr`, `rptr` (LOG2_DEPTH bits each, modulo wrap), `count`, and the registered status flags.
- Write acceptance: `wacc = we && (count != CAP)`. An accepted write stores `wdata` at `mem[wptr]` and increments `wptr`.
- Read acceptance: `racc = re && (count != 0)`. An accepted read increments `rptr`.
- Full and empty decisions use the current registered `count` only. There is no write-to-read pass-through.
- Rejected requests have no effect on pointers, memory, or `count`:
  - `we` while full: write dropped.
  - `re` while empty: read ignored and no `rvalid` is produced.
- Count update: `count_next = count + wacc - racc`. The arithmetic is LOG2_DEPTH bits wide and never wraps, because of the acceptance rules.
- Simultaneous `wacc` and `racc`: `count` is unchanged and both pointers advance.
- `re` together with `we` while empty: only the write is accepted.
- `we` together with `re` while full: only the read is accepted, and the write is dropped.
- Flags are registered from `count_next`:
  - `empty = (count_next == 0)`
  - `almostfull = (count_next >= CAP - ALMOSTFULL_SLACK)`
- Pointers wrap from `2**LOG2_DEPTH - 1` to 0. `CAP` is one less than the memory size, so pointers never collide while the FIFO is full.
- `reset` mid-operation:
  - Pointers, `count`, `rvalid`, `rdata`, and `error` all clear and `empty` is set on the next edge.
  - Memory contents are not cleared.
  - Any read response that was in flight is squashed.

## Timing
- Write: `we` accepted at edge t makes the entry visible at t+1 (`count` incremented, `empty` low at t+1). The earliest read of that entry is at t+1.
- Read latency is 1 cycle: `racc` at edge t gives `rdata = mem[rptr]` and `rvalid = 1` at t+1. `rvalid` is 0 in every cycle that has no accepted read at the prior edge.
- Back-to-back reads sustain one word per cycle. `rdata` holds its last value while `rvalid = 0`.
- `almostfull` and `count` are registered, so a producer sees back-pressure one cycle late. `ALMOSTFULL_SLACK` must cover the producer's pipeline depth plus 1.

## Configuration
- `PIPEARCH_FIFO_CHECK_EN` defined:
  - `error[1]` is set sticky on `we && count == CAP`.
  - `error[0]` is set sticky on `re && count == 0`.
  - A simulation `$error` is issued at the offending edge.
  - Both bits clear only on `reset`.
- `PIPEARCH_FIFO_CHECK_EN` undefined: `error` is constant 0 and no check logic or assertions are synthesized. Data-path behaviour is identical in both builds.

## Structure
- `fifobram_interface` stays in the shared common header, alongside `LOG2_PREFETCH_SIZE`/`PREFETCH_SIZE`.
- A new shared-header localparam-free typedef `t_fifo_error` is added as a packed struct {overflow, underflow}.
- One sub-module, `pipearch_sdp_bram`, handles storage:
  - Simple dual-port memory with a registered read port (`we`, `waddr`, `wdata`, `re`, `raddr`, `rdata`) and 1-cycle latency.
  - Inferred as BRAM.
- Pointers, count, flags, and the `rvalid` pipeline register live in the top module.

## Test plan
- After reset, write 0xA0..0xA4 on consecutive cycles, then read 5 times back-to-back. Required: `rdata` is 0xA0..0xA4 in order, `rvalid` is high for 5 consecutive cycles each one cycle after its `re`, and `count` ends at 0 with `empty = 1`.
- Defaults (CAP = 31, slack 4): write 27 words. Required: `almostfull` rises in the cycle `count` becomes 27 and is still 0 at `count = 26`.
- Fill to 31 and hold `we` with data 0xFF. Required: `count` stays 31, the data is dropped, and `error = 2'b10` when the macro is enabled. Then 31 reads return the original data with no 0xFF.
- With `count = 10`, assert `re` and `we` together for 40 cycles. Required: `count` stays 10, pointers wrap past 31, and data order is preserved.
- From the empty state, assert `re` and `we` (0x55) in the same cycle. Required: no `rvalid` next cycle, `count = 1`, and `error[0] = 1` when the macro is enabled. The next `re` returns 0x55.
- Assert `reset` with 5 entries stored and a read in flight. Required: `rvalid` is 0 next cycle, `count` is 0, `empty` is 1, and `error` is 0.

Source files
------------

// File: rtl/pipearch_fifo_source_pkg.sv
// -----------------------------------------------------------------------------
// pipearch_fifo_source_pkg
// Shared common header for the PipeArch FIFO slice.
//   - LOG2_PREFETCH_SIZE / PREFETCH_SIZE : prefetch sizing shared by engines
//   - t_fifo_error                       : sticky FIFO error flags {overflow, underflow}
// The companion interface fifobram_interface lives in rtl/fifobram_interface.sv.
// Optional macro used by the importers: PIPEARCH_FIFO_CHECK_EN.
// -----------------------------------------------------------------------------
package pipearch_fifo_source_pkg;

  localparam int LOG2_PREFETCH_SIZE = 9;
  localparam int PREFETCH_SIZE      = 2 ** LOG2_PREFETCH_SIZE;

  typedef struct packed {
    logic overflow;
    logic underflow;
  } t_fifo_error;

endpackage

// File: rtl/fifobram_interface.sv
// -----------------------------------------------------------------------------
// fifobram_interface
// Connection bundle between a producer, a consumer and a BRAM-backed FIFO.
// Parameters: WIDTH (data word width), LOG2_DEPTH (address/count width).
// Modports:
//   fifo_source : the FIFO itself (takes we/wdata/re, drives read response + status)
//   fifo_write  : producer side (drives we/wdata, watches almostfull/count)
//   fifo_read   : consumer side (drives re, watches rdata/rvalid/empty/count)
// Optional macro: PIPEARCH_FIFO_CHECK_EN (consumed by the FIFO, not here).
// -----------------------------------------------------------------------------
interface fifobram_interface #(
  parameter int WIDTH      = 32,
  parameter int LOG2_DEPTH = 5
);

  logic                  we;
  logic [WIDTH-1:0]      wdata;
  logic                  re;
  logic [WIDTH-1:0]      rdata;
  logic                  rvalid;
  logic                  almostfull;
  logic                  empty;
  logic [LOG2_DEPTH-1:0] count;

  modport fifo_source (
    input  we, wdata, re,
    output rdata, rvalid, almostfull, empty, count
  );

  modport fifo_write (
    output we, wdata,
    input  almostfull, count
  );

  modport fifo_read (
    output re,
    input  rdata, rvalid, empty, count
  );

endinterface

// File: rtl/pipearch_sdp_bram.sv
// -----------------------------------------------------------------------------
// pipearch_sdp_bram
// Simple dual-port RAM with one write port and one registered read port
// (1-cycle read latency), written so synthesis maps it onto block RAM.
// Ports:
//   clk, reset   : clock and synchronous active-high reset (read register only)
//   we/waddr/wdata : write port
//   re/raddr       : read request; rdata is updated one edge later
//   rdata          : registered read data, holds its value while re is low
// Optional macro: PIPEARCH_FIFO_CHECK_EN (not used here).
// -----------------------------------------------------------------------------
module pipearch_sdp_bram #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  // Storage array is never reset so it stays a plain BRAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Output register uses the BRAM's own output reset; without a read it holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/pipearch_fifo_source.sv
// -----------------------------------------------------------------------------
// pipearch_fifo_source
// BRAM-backed synchronous FIFO implementing the fifo_source side of
// fifobram_interface. Capacity is 2**LOG2_DEPTH - 1 so count fits in
// LOG2_DEPTH bits and the pointers never collide while full.
// Ports:
//   clk    : clock
//   reset  : synchronous active-high reset
//   fifo   : fifobram_interface.fifo_source (we/wdata/re in; rdata/rvalid/
//            almostfull/empty/count out, all registered)
//   error  : sticky {overflow, underflow}
// Optional macro: PIPEARCH_FIFO_CHECK_EN enables the sticky error flags and
// a simulation $error on misuse; otherwise error is constant 0.
// -----------------------------------------------------------------------------
module pipearch_fifo_source
  import pipearch_fifo_source_pkg::*;
#(
  parameter int WIDTH            = 32,
  parameter int LOG2_DEPTH       = 5,
  parameter int ALMOSTFULL_SLACK = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  fifobram_interface.fifo_source fifo,
  output logic [1:0]             error
);

  localparam int CAP = (2 ** LOG2_DEPTH) - 1;
  localparam logic [LOG2_DEPTH-1:0] CAP_CNT  = LOG2_DEPTH'(CAP);
  localparam logic [LOG2_DEPTH-1:0] AF_LEVEL = LOG2_DEPTH'(CAP - ALMOSTFULL_SLACK);
  localparam logic [LOG2_DEPTH-1:0] ONE      = LOG2_DEPTH'(1);

  logic [LOG2_DEPTH-1:0] wptr;
  logic [LOG2_DEPTH-1:0] rptr;
  logic [LOG2_DEPTH-1:0] count_q;
  logic [LOG2_DEPTH-1:0] count_next;
  logic                  empty_q;
  logic                  almostfull_q;
  logic                  rvalid_q;
  logic                  wacc;
  logic                  racc;

  // Acceptance looks only at the registered count: no write-to-read bypass.
  assign wacc = fifo.we && (count_q != CAP_CNT);
  assign racc = fifo.re && (count_q != '0);

  always_comb begin
    count_next = count_q;
    if (wacc && !racc) begin
      count_next = count_q + ONE;
    end else if (racc && !wacc) begin
      count_next = count_q - ONE;
    end
  end

  // Pointers wrap naturally at LOG2_DEPTH bits; flags are precomputed from
  // count_next so they are registered alongside count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr         <= '0;
      rptr         <= '0;
      count_q      <= '0;
      empty_q      <= 1'b1;
      almostfull_q <= 1'b0;
      rvalid_q     <= 1'b0;
    end else begin
      if (wacc) begin
        wptr <= wptr + ONE;
      end
      if (racc) begin
        rptr <= rptr + ONE;
      end
      count_q      <= count_next;
      empty_q      <= (count_next == '0);
      almostfull_q <= (count_next >= AF_LEVEL);
      rvalid_q     <= racc;
    end
  end

  pipearch_sdp_bram #(
    .WIDTH  (WIDTH),
    .ADDR_W (LOG2_DEPTH)
  ) u_bram (
    .clk   (clk),
    .reset (reset),
    .we    (wacc),
    .waddr (wptr),
    .wdata (fifo.wdata),
    .re    (racc),
    .raddr (rptr),
    .rdata (fifo.rdata)
  );

  assign fifo.rvalid     = rvalid_q;
  assign fifo.empty      = empty_q;
  assign fifo.almostfull = almostfull_q;
  assign fifo.count      = count_q;

`ifdef PIPEARCH_FIFO_CHECK_EN
  t_fifo_error err_q;

  // Misuse flags latch until reset so a late look still shows what happened.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= '0;
    end else begin
      if (fifo.we && (count_q == CAP_CNT)) begin
        err_q.overflow <= 1'b1;
      end
      if (fifo.re && (count_q == '0)) begin
        err_q.underflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && fifo.we && (count_q == CAP_CNT)) begin
      $error("pipearch_fifo_source: write while full");
    end
    if (!reset && fifo.re && (count_q == '0)) begin
      $error("pipearch_fifo_source: read while empty");
    end
  end

  assign error = err_q;
`else
  assign error = 2'b00;
`endif

endmodule

// File: tb/tb_pipearch_fifo_source.sv
// -----------------------------------------------------------------------------
// tb_pipearch_fifo_source
// Self-checking bench for pipearch_fifo_source with a reference queue model
// and a read-response scoreboard. Honours PIPEARCH_FIFO_CHECK_EN when
// predicting the error output.
// -----------------------------------------------------------------------------
module tb_pipearch_fifo_source;

  localparam int WIDTH = 32;
  localparam int LOG2_DEPTH = 5;
  localparam int SLACK = 4;
  localparam int CAP = (2 ** LOG2_DEPTH) - 1;

  logic       clk;
  logic       reset;
  logic [1:0] error;

  fifobram_interface #(.WIDTH(WIDTH), .LOG2_DEPTH(LOG2_DEPTH)) fifo_if ();

  pipearch_fifo_source #(
    .WIDTH            (WIDTH),
    .LOG2_DEPTH       (LOG2_DEPTH),
    .ALMOSTFULL_SLACK (SLACK)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .fifo  (fifo_if),
    .error (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] model_q[$];
  logic [WIDTH-1:0] sb_q[$];
  logic [WIDTH-1:0] exp_rdata;
  logic             exp_ov;
  logic             exp_un;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Compares every registered output against the model after an edge.
  task automatic checkStatus();
    logic [1:0] exp_err;
`ifdef PIPEARCH_FIFO_CHECK_EN
    exp_err = {exp_ov, exp_un};
`else
    exp_err = 2'b00;
`endif
    checkOutput("count", 64'(fifo_if.count), 64'(model_q.size()));
    checkOutput("empty", 64'(fifo_if.empty), 64'(model_q.size() == 0));
    checkOutput("almostfull", 64'(fifo_if.almostfull), 64'(model_q.size() >= CAP - SLACK));
    checkOutput("error", 64'(error), 64'(exp_err));
  endtask

  // Drives one cycle of requests, updates the model at the edge and checks
  // the response one time unit later.
  task automatic applyStimulus(input logic we, input logic [WIDTH-1:0] wd, input logic re);
    logic wacc;
    logic racc;
    fifo_if.we    = we;
    fifo_if.wdata = wd;
    fifo_if.re    = re;
    racc = re && (model_q.size() != 0);
    wacc = we && (model_q.size() != CAP);
    if (we && model_q.size() == CAP) exp_ov = 1'b1;
    if (re && model_q.size() == 0) exp_un = 1'b1;
    @(posedge clk);
    if (racc) begin
      exp_rdata = model_q.pop_front();
      sb_q.push_back(exp_rdata);
    end
    if (wacc) model_q.push_back(wd);
    #1;
    fifo_if.we = 1'b0;
    fifo_if.re = 1'b0;
    checkOutput("rvalid", 64'(fifo_if.rvalid), 64'(racc));
    if (fifo_if.rvalid) begin
      if (sb_q.size() == 0) checkOutput("sb_unexpected_rvalid", 64'(1), 64'(0));
      else checkOutput("rdata", 64'(fifo_if.rdata), 64'(sb_q.pop_front()));
    end else begin
      checkOutput("rdata_hold", 64'(fifo_if.rdata), 64'(exp_rdata));
    end
    checkStatus();
  endtask

  task automatic doReset(input logic re);
    reset      = 1'b1;
    fifo_if.re = re;
    fifo_if.we = 1'b0;
    @(posedge clk);
    model_q.delete();
    sb_q.delete();
    exp_rdata = '0;
    exp_ov    = 1'b0;
    exp_un    = 1'b0;
    #1;
    fifo_if.re = 1'b0;
    reset      = 1'b0;
    checkOutput("reset_rvalid", 64'(fifo_if.rvalid), 64'(0));
    checkOutput("reset_rdata", 64'(fifo_if.rdata), 64'(0));
    checkStatus();
  endtask

  initial begin
    reset         = 1'b1;
    fifo_if.we    = 1'b0;
    fifo_if.re    = 1'b0;
    fifo_if.wdata = '0;
    exp_rdata     = '0;
    exp_ov        = 1'b0;
    exp_un        = 1'b0;
    @(posedge clk);
    #1;
    doReset(1'b0);

    // Basic ordered write then back-to-back read.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, WIDTH'(32'hA0 + i), 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, 1'b1);

    // Fill through the almostfull threshold, then overflow with 0xFF.
    for (int i = 0; i < CAP; i++) applyStimulus(1'b1, WIDTH'(32'h100 + i), 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, WIDTH'(32'hFF), 1'b0);
    for (int i = 0; i < CAP; i++) applyStimulus(1'b0, '0, 1'b1);

    // Steady state at count 10 with simultaneous read and write; wraps pointers.
    doReset(1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, WIDTH'(32'h200 + i), 1'b0);
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, WIDTH'(32'h300 + i), 1'b1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, 1'b1);

    // Read and write together while empty: only the write lands.
    applyStimulus(1'b1, WIDTH'(32'h55), 1'b1);
    applyStimulus(1'b0, '0, 1'b1);

    // Reset with entries stored and a read in progress.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, WIDTH'(32'h400 + i), 1'b0);
    applyStimulus(1'b0, '0, 1'b1);
    doReset(1'b1);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), WIDTH'($urandom), 1'($urandom_range(0, 1)));
    end
    while (model_q.size() != 0) applyStimulus(1'b0, '0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
